spectrogram_frame_receiver: RTL and testbench

- Downstream consumer of the spectrogram extractor's serial readout. Samples the serial data line, its shift/load strobe and the global overflow flag, rebuilds each 16-word frame of 12-bit words: word 0 is the RTC min/sec, words 1-15 are the channel counts.
- Buffers rebuilt words in a small FIFO and presents them on a valid/ready stream with word index and last-word marker, for a host-side logger or a UART packer.

---
 rtl/spectro_pkg.sv | 14 +
 rtl/spectro_word_fifo.sv | 53 +++++
 rtl/spectrogram_frame_receiver.sv | 199 +++++++++++++++++++
 tb/tb_spectrogram_frame_receiver.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectro_pkg.sv
// Shared constants and FSM state type for the spectrogram frame receiver.
package spectro_pkg;

    localparam int unsigned DEF_WORD_W    = 12;
    localparam int unsigned DEF_NUM_WORDS = 16;
    localparam int unsigned IDX_W         = 4;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitLoad = 2'd1,
        StShift    = 2'd2
    } rx_state_e;

endpackage

// File: rtl/spectro_word_fifo.sv
// First-word-fall-through word buffer. The head entry is presented combinationally;
// a push and a pop on the same edge are both honoured, even when full.
module spectro_word_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign valid     = (count_q != '0);
    assign do_pop    = pop && valid;
    // A full FIFO still accepts a word when the head leaves on the same edge
    assign do_push   = push && (!full || do_pop);
    assign head_data = valid ? mem[rptr_q] : '0;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= push_data;
    end

endmodule

// File: rtl/spectrogram_frame_receiver.sv
// Rebuilds 16-word frames (RTC word + 15 channel counts) from the extractor's serial readout
// and streams the words out through a small FWFT FIFO with index and last-word tags.
// Optional: define SPECTRO_RX_CHECKSUM_EN to append an XOR checksum word to every frame.
module spectrogram_frame_receiver
    import spectro_pkg::*;
#(
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              sl_in,
    input  logic              ovf_in,
    output logic [WORD_W-1:0] m_data,
    output logic [IDX_W-1:0]  m_idx,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overrun,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned      CNT_W    = $clog2(WORD_W + 1);
    localparam int unsigned      ENT_W    = WORD_W + IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    rx_state_e         state_q, state_d;
    logic              ovf_q, ovf_rise;
    logic [WORD_W-1:0] shift_q, shift_d, shifted;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              word_done, word_push, frame_start;
    logic              push, pop, fifo_full, fifo_valid;
    logic [ENT_W-1:0]  push_data, head_data;
`ifdef SPECTRO_RX_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q, csum_d;
    logic              csum_pend_q, csum_pend_d;
`endif

    assign ovf_rise  = ovf_in && !ovf_q;
    assign shifted   = {shift_q[WORD_W-2:0], serial_in};
    assign word_done = (bit_cnt_q == LAST_BIT);
    assign pop       = fifo_valid && m_ready;

    // State register; ovf is sampled even in reset so a level held through reset is no rise
    always_ff @(posedge clk) begin
        ovf_q <= ovf_in;
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state: ovf rise always (re)starts a frame at the load wait
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (ovf_rise) state_d = StWaitLoad;
            end
            StWaitLoad: begin
                if (!ovf_rise && !sl_in) state_d = StShift;
            end
            StShift: begin
                if (ovf_rise) begin
                    state_d = StWaitLoad;
                end else if (sl_in && word_done) begin
                    state_d = (idx_q == LAST_IDX) ? StIdle : StWaitLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state, FIFO push and sticky flags
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        frame_err_d = frame_err_q;
        word_push   = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            StIdle: begin
                frame_start = ovf_rise;
            end
            StWaitLoad: begin
                if (ovf_rise) begin
                    frame_start = 1'b1;
                    frame_err_d = 1'b1;
                end else if (!sl_in) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            StShift: begin
                if (ovf_rise) begin
                    frame_start = 1'b1;
                    frame_err_d = 1'b1;
                end else if (!sl_in) begin
                    // Short word: this load cycle restarts the same index
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                end else if (word_done) begin
                    word_push = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = shifted;
                    idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
`ifndef SPECTRO_RX_CHECKSUM_EN
                    if (idx_q == LAST_IDX) frame_cnt_d = frame_cnt_q + 1'b1;
`endif
                end else begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (frame_start) begin
            idx_d     = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end
`ifdef SPECTRO_RX_CHECKSUM_EN
        // Checksum goes out the cycle after word 15; no word push can collide with it
        csum_d      = csum_q;
        csum_pend_d = word_push && (idx_q == LAST_IDX);
        if (frame_start)    csum_d = '0;
        else if (word_push) csum_d = csum_q ^ shifted;
        if (csum_pend_q) frame_cnt_d = frame_cnt_q + 1'b1;
        push      = word_push || csum_pend_q;
        push_data = csum_pend_q ? {csum_q, {IDX_W{1'b1}}, 1'b1} : {shifted, idx_q, 1'b0};
`else
        push      = word_push;
        push_data = {shifted, idx_q, (idx_q == LAST_IDX)};
`endif
        overrun_d = overrun_q | (push && fifo_full && !pop);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SPECTRO_RX_CHECKSUM_EN
    // Running XOR of the current frame and the pending checksum push
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q      <= '0;
            csum_pend_q <= 1'b0;
        end else begin
            csum_q      <= csum_d;
            csum_pend_q <= csum_pend_d;
        end
    end
`endif

    spectro_word_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .valid     (fifo_valid),
        .full      (fifo_full)
    );

    assign {m_data, m_idx, m_last} = head_data;
    assign m_valid   = fifo_valid;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spectrogram_frame_receiver.sv
// Randomised bench for spectrogram_frame_receiver: a queue-based model of the word stream,
// checked against the DUT on every cycle, plus literal expectations per scenario.
// Honours SPECTRO_RX_CHECKSUM_EN when the build defines it.
module tb_spectrogram_frame_receiver;

    localparam int DEPTH = 8;
`ifdef SPECTRO_RX_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
    localparam int NB   = 17;
`else
    localparam bit CSUM = 1'b0;
    localparam int NB   = 16;
`endif

    typedef struct packed {
        logic [11:0] data;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, serial_in, sl_in, ovf_in, m_ready;
    logic [11:0] m_data;
    logic [3:0]  m_idx;
    logic        m_last, m_valid, overrun, frame_err;
    logic [7:0]  frame_cnt;

    spectrogram_frame_receiver #(
        .WORD_W     (12),
        .NUM_WORDS  (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .sl_in     (sl_in),
        .ovf_in    (ovf_in),
        .m_data    (m_data),
        .m_idx     (m_idx),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .overrun   (overrun),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    ready_mode = 0;  // 0 always ready, 1 never, 2 toggle, 3 random
    beat_t model_q[$];
    beat_t dut_beats[$];
    logic       exp_ovr = 1'b0;
    logic       exp_err = 1'b0;
    logic [7:0] exp_fc  = 8'd0;
    // Events the stimulus announces for the coming clock edge
    logic  ev_push  = 1'b0;
    logic  ev_err   = 1'b0;
    logic  ev_frame = 1'b0;
    beat_t ev_beat  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded word queue with the overrun and sticky-flag rules
    always @(posedge clk) begin
        logic popped;
        if (reset) begin
            model_q.delete();
            exp_ovr <= 1'b0;
            exp_err <= 1'b0;
            exp_fc  <= 8'd0;
        end else begin
            popped = (model_q.size() > 0) && m_ready;
            if (popped) void'(model_q.pop_front());
            if (ev_push) begin
                if (model_q.size() == DEPTH) exp_ovr <= 1'b1;
                else model_q.push_back(ev_beat);
            end
            if (ev_err)   exp_err <= 1'b1;
            if (ev_frame) exp_fc  <= exp_fc + 8'd1;
        end
    end

    // Per-cycle comparison, half a period away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            check("m_valid", 32'(m_valid), 32'(model_q.size() > 0));
            if (model_q.size() > 0) begin
                check("m_data", 32'(m_data), 32'(model_q[0].data));
                check("m_idx",  32'(m_idx),  32'(model_q[0].idx));
                check("m_last", 32'(m_last), 32'(model_q[0].last));
            end
            check("overrun",   32'(overrun),   32'(exp_ovr));
            check("frame_err", 32'(frame_err), 32'(exp_err));
            check("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
            if (m_valid && m_ready) dut_beats.push_back('{data: m_data, idx: m_idx, last: m_last});
        end
    end

    task automatic drive(input logic sl, input logic sd, input logic ov);
        @(posedge clk);
        #1;
        sl_in     = sl;
        serial_in = sd;
        ovf_in    = ov;
        ev_push   = 1'b0;
        ev_err    = 1'b0;
        ev_frame  = 1'b0;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            2:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        dut_beats.delete();
        check("rst m_valid",   32'(m_valid),   32'd0);
        check("rst m_data",    32'(m_data),    32'd0);
        check("rst m_idx",     32'(m_idx),     32'd0);
        check("rst m_last",    32'(m_last),    32'd0);
        check("rst overrun",   32'(overrun),   32'd0);
        check("rst frame_err", 32'(frame_err), 32'd0);
        check("rst frame_cnt", 32'(frame_cnt), 32'd0);
    endtask

    // One load cycle then 12 shift bits MSB first; short_bits > 0 inserts a short word first
    task automatic send_word(input logic [11:0] w, input logic [3:0] idx, input logic last,
                             input int short_bits);
        drive(1'b0, 1'b0, 1'b0);
        if (short_bits > 0) begin
            for (int i = 0; i < short_bits; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            drive(1'b0, 1'b0, 1'b0);
            ev_err = 1'b1;
        end
        for (int b = 11; b >= 0; b--) drive(1'b1, w[b], 1'b0);
        ev_push = 1'b1;
        ev_beat = '{data: w, idx: idx, last: last};
    endtask

    task automatic send_frame(input logic [11:0] w[16], input int short_idx, input int short_bits,
                              input int abort_idx);
        logic [11:0] x;
        int          k;
        x = '0;
        drive(1'b1, 1'b0, 1'b1);
        if (abort_idx >= 0) begin
            for (int i = 0; i < abort_idx; i++) begin
                gap();
                send_word(w[i], 4'(i), 1'b0, 0);
            end
            gap();
            drive(1'b0, 1'b0, 1'b0);
            k = $urandom_range(1, 11);
            for (int i = 0; i < k; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            drive(1'b1, 1'b0, 1'b1);
            ev_err = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            gap();
            send_word(w[i], 4'(i), (i == 15) && !CSUM, (i == short_idx) ? short_bits : 0);
            x ^= w[i];
            if (i == 15 && !CSUM) ev_frame = 1'b1;
        end
        drive(1'b1, 1'b0, 1'b0);
        if (CSUM) begin
            ev_push  = 1'b1;
            ev_beat  = '{data: x, idx: 4'hF, last: 1'b1};
            ev_frame = 1'b1;
        end
    endtask

    logic [11:0] words[16];

    initial begin
        reset = 1'b1;
        sl_in = 1'b1;
        serial_in = 1'b0;
        ovf_in = 1'b0;
        m_ready = 1'b1;

        // Basic frame, always ready
        do_reset();
        for (int i = 0; i < 16; i++) words[i] = 12'(i);
        words[0] = 12'h105;
        send_frame(words, -1, 0, -1);
        idle(12);
        check("t1 beats", 32'(dut_beats.size()), 32'(NB));
        check("t1 word0", 32'(dut_beats[0].data), 32'h105);
        for (int i = 0; i < 16; i++) begin
            check("t1 idx",  32'(dut_beats[i].idx),  32'(i));
            check("t1 last", 32'(dut_beats[i].last), 32'((i == 15) && !CSUM));
        end
        check("t1 frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1 overrun",   32'(overrun),   32'd0);
        check("t1 frame_err", 32'(frame_err), 32'd0);

        // Short word in word 3, then a clean resend of 0xABC
        do_reset();
        words[3] = 12'hABC;
        send_frame(words, 3, 7, -1);
        idle(12);
        check("t3 frame_err", 32'(frame_err), 32'd1);
        check("t3 beats", 32'(dut_beats.size()), 32'(NB));
        check("t3 idx3",  32'(dut_beats[3].idx),  32'd3);
        check("t3 data3", 32'(dut_beats[3].data), 32'hABC);

        // Abort during word 9
        do_reset();
        send_frame(words, -1, 0, 9);
        idle(12);
        check("t4 frame_err", 32'(frame_err), 32'd1);
        check("t4 beats", 32'(dut_beats.size()), 32'(9 + NB));
        check("t4 pre idx", 32'(dut_beats[8].idx), 32'd8);
        check("t4 restart idx", 32'(dut_beats[9].idx), 32'd0);
        check("t4 frame_cnt", 32'(frame_cnt), 32'd1);

        // Toggling ready while words stream in
        do_reset();
        ready_mode = 2;
        send_frame(words, -1, 0, -1);
        ready_mode = 0;
        idle(12);
        check("t5 beats", 32'(dut_beats.size()), 32'(NB));
        for (int i = 0; i < 16; i++) check("t5 order", 32'(dut_beats[i].idx), 32'(i));

        // Checksum frame 0x001..0x010: XOR of all words is 0x010
        do_reset();
        for (int i = 0; i < 16; i++) words[i] = 12'(i + 1);
        send_frame(words, -1, 0, -1);
        idle(12);
        check("t6 beats", 32'(dut_beats.size()), 32'(NB));
        check("t6 w15 last", 32'(dut_beats[15].last), 32'(!CSUM));
        if (CSUM) begin
            check("t6 csum idx",  32'(dut_beats[16].idx),  32'hF);
            check("t6 csum data", 32'(dut_beats[16].data), 32'h010);
            check("t6 csum last", 32'(dut_beats[16].last), 32'd1);
        end

        // Random frames, random backpressure, occasional short words and one abort
        do_reset();
        ready_mode = 3;
        for (int f = 0; f < 6; f++) begin
            int sidx;
            for (int i = 0; i < 16; i++) words[i] = 12'($urandom_range(0, 4095));
            sidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
            send_frame(words, sidx, int'($urandom_range(1, 11)), (f == 2) ? 5 : -1);
        end
        ready_mode = 0;
        idle(12);
        check("rnd frame_cnt", 32'(frame_cnt), 32'd6);

        // Never ready: FIFO fills to 8, later words are dropped
        do_reset();
        ready_mode = 1;
        words[0] = 12'h105;
        for (int i = 1; i < 16; i++) words[i] = 12'(i);
        send_frame(words, -1, 0, -1);
        idle(3);
        check("t2 valid",   32'(m_valid),   32'd1);
        check("t2 data",    32'(m_data),    32'h105);
        check("t2 idx",     32'(m_idx),     32'd0);
        check("t2 overrun", 32'(overrun),   32'd1);
        check("t2 frame_cnt", 32'(frame_cnt), 32'd1);
        ready_mode = 0;
        idle(12);
        check("t2 held", 32'(dut_beats.size()), 32'd8);
        check("t2 tail idx", 32'(dut_beats[7].idx), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
